prio_enc_sched: RTL and testbench



---
 rtl/prio_enc_sched_pkg.sv | 17 +
 rtl/prio_enc_sched_if.sv | 28 ++
 rtl/prio_enc_sched_pick.sv | 48 ++++
 rtl/prio_enc_sched.sv | 76 +++++++
 tb/tb_prio_enc_sched.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/prio_enc_sched_pkg.sv
// Shared constants and helpers for the priority-encoder scheduler.
package prio_enc_sched_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Ceiling log2 for v >= 2; used to size encoded indices.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc_sched_if.sv
// Request/issue bundle between event sources, scheduler and consumer.
interface prio_enc_sched_if
    import prio_enc_sched_pkg::*;
#(
    parameter int N = 16,
    parameter int W = clog2(N)
) ();
    logic         en;
    logic [N-1:0] req;
    logic         clr_all;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] pending;
    logic         lost;

    // Source/consumer side.
    modport master (
        output en, req, clr_all, out_ready,
        input  out_valid, out_idx, pending, lost
    );

    // Scheduler side.
    modport slave (
        input  en, req, clr_all, out_ready,
        output out_valid, out_idx, pending, lost
    );
endinterface

// File: rtl/prio_enc_sched_pick.sv
// Combinational picker: highest set bit (fixed) or first set bit at or
// after start with wrap-around (round-robin).
module prio_pick #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    input  logic         rr,
    output logic [W-1:0] idx,
    output logic         hit
);

    logic [N-1:0] w_upper;
    logic [W-1:0] w_hi_idx;
    logic [W-1:0] w_lo_all;
    logic [W-1:0] w_lo_upper;

    // Bits at or above the round-robin start point.
    always_comb begin
        w_upper = '0;
        for (int i = 0; i < N; i++) begin
            w_upper[i] = vec[i] && (i >= int'(start));
        end
    end

    // Highest set bit of vec, lowest set bit of vec and of the upper slice.
    always_comb begin
        w_hi_idx   = '0;
        w_lo_all   = '0;
        w_lo_upper = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) w_hi_idx = W'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i])     w_lo_all   = W'(i);
            if (w_upper[i]) w_lo_upper = W'(i);
        end
    end

    // The wrapped scan is the upper slice first, else the lowest bit overall.
    always_comb begin
        hit = |vec;
        if (rr) idx = (|w_upper) ? w_lo_upper : w_lo_all;
        else    idx = w_hi_idx;
    end

endmodule

// File: rtl/prio_enc_sched.sv
// Registered priority-encoder scheduler: sticky pending vector feeding a
// one-entry valid/ready output slot, fixed or round-robin selection.
module prio_enc_sched
    import prio_enc_sched_pkg::*;
#(
    parameter int N       = 16,
    parameter int W       = clog2(N),
    parameter int RR_MODE = MODE_FIXED
) (
    input  logic            clk,
    input  logic            rst,
    prio_enc_sched_if.slave bus
);

    logic [N-1:0] r_pending;
    logic         r_valid;
    logic [W-1:0] r_idx;
    logic         r_lost;
    logic [W-1:0] r_ptr;

    logic         w_load;
    logic         w_hit;
    logic [W-1:0] w_sel;
    logic [N-1:0] w_load_mask;
    logic [N-1:0] w_req;
    logic [W-1:0] w_ptr_nxt;

    prio_pick #(.N(N), .W(W)) u_pick (
        .vec   (r_pending),
        .start (r_ptr),
        .rr    (RR_MODE == MODE_RR),
        .idx   (w_sel),
        .hit   (w_hit)
    );

    // Slot reloads when empty or being drained; the picked bit leaves pending.
    always_comb begin
        w_load      = !r_valid || bus.out_ready;
        w_load_mask = (w_load && w_hit) ? ({{(N-1){1'b0}}, 1'b1} << w_sel) : '0;
        w_req       = bus.en ? bus.req : '0;
        w_ptr_nxt   = (w_sel == W'(N - 1)) ? '0 : w_sel + 1'b1;
    end

    // Pending, output slot, round-robin pointer and lost flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_lost    <= 1'b0;
            r_ptr     <= '0;
        end else if (bus.clr_all) begin
            // Flush drops same-cycle requests; ptr and idx keep their values.
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_lost    <= 1'b0;
        end else begin
            // A new request on the bit being loaded is a fresh event: set wins.
            r_pending <= (r_pending & ~w_load_mask) | w_req;
            if (|(w_req & r_pending & ~w_load_mask)) r_lost <= 1'b1;
            if (w_load) begin
                r_valid <= w_hit;
                if (w_hit) begin
                    r_idx <= w_sel;
                    if (RR_MODE == MODE_RR) r_ptr <= w_ptr_nxt;
                end
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_idx   = r_idx;
    assign bus.pending   = r_pending;
    assign bus.lost      = r_lost;

endmodule

// File: tb/tb_prio_enc_sched.sv
// Scoreboard bench: three schedulers (fixed N=16, RR N=16, RR N=10) share
// stimulus; a reference model pushes each issued index, a monitor pops them.
module tb_prio_enc_sched;

    logic        clk;
    logic        rst;
    logic        en;
    logic        clr;
    logic        rdy;
    logic [15:0] req;

    int tests = 0;
    int fails = 0;

    prio_enc_sched_if #(.N(16)) if0 ();
    prio_enc_sched_if #(.N(16)) if1 ();
    prio_enc_sched_if #(.N(10)) if2 ();

    assign if0.en = en;  assign if0.clr_all = clr; assign if0.out_ready = rdy; assign if0.req = req;
    assign if1.en = en;  assign if1.clr_all = clr; assign if1.out_ready = rdy; assign if1.req = req;
    assign if2.en = en;  assign if2.clr_all = clr; assign if2.out_ready = rdy; assign if2.req = req[9:0];

    prio_enc_sched #(.N(16), .RR_MODE(0)) u_fix16 (.clk(clk), .rst(rst), .bus(if0));
    prio_enc_sched #(.N(16), .RR_MODE(1)) u_rr16  (.clk(clk), .rst(rst), .bus(if1));
    prio_enc_sched #(.N(10), .RR_MODE(1)) u_rr10  (.clk(clk), .rst(rst), .bus(if2));

    logic [15:0] dpend [3];
    logic        dvld  [3];
    logic [31:0] didx  [3];
    logic        dlost [3];

    assign dpend[0] = if0.pending;          assign dpend[1] = if1.pending;
    assign dpend[2] = {6'b0, if2.pending};
    assign dvld[0]  = if0.out_valid;        assign dvld[1]  = if1.out_valid;
    assign dvld[2]  = if2.out_valid;
    assign didx[0]  = 32'(if0.out_idx);     assign didx[1]  = 32'(if1.out_idx);
    assign didx[2]  = 32'(if2.out_idx);
    assign dlost[0] = if0.lost;             assign dlost[1] = if1.lost;
    assign dlost[2] = if2.lost;

    // Reference model state per instance.
    int          NN [3] = '{16, 16, 10};
    bit          RR [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] pm [3];
    bit          vm [3];
    bit          lm [3];
    int          pt [3];
    int          exp_q [3][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int n, input bit rr, input logic [15:0] v, input int ptr);
        if (rr) begin
            for (int k = 0; k < n; k++) begin
                int i;
                i = (ptr + k) % n;
                if (v[i]) return i;
            end
        end else begin
            for (int i = n - 1; i >= 0; i--) if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] nmask(input int n);
        return (n == 16) ? 16'hFFFF : ((16'(1) << n) - 16'd1);
    endfunction

    // Model: advance on each clock edge, clear at once on reset.
    initial begin
        for (int k = 0; k < 3; k++) begin
            pm[k] = '0; vm[k] = 0; lm[k] = 0; pt[k] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            for (int k = 0; k < 3; k++) begin
                if (rst) begin
                    pm[k] = '0; vm[k] = 0; lm[k] = 0; pt[k] = 0;
                    exp_q[k].delete();
                end else if (clr) begin
                    pm[k] = '0; vm[k] = 0; lm[k] = 0;
                    exp_q[k].delete();
                end else begin
                    logic [15:0] taken, newreq;
                    int sel;
                    taken  = '0;
                    newreq = en ? (req & nmask(NN[k])) : '0;
                    if (!vm[k] || rdy) begin
                        sel = pick(NN[k], RR[k], pm[k], pt[k]);
                        if (sel >= 0) begin
                            vm[k] = 1;
                            taken = 16'(1) << sel;
                            exp_q[k].push_back(sel);
                            if (RR[k]) pt[k] = (sel + 1) % NN[k];
                        end else begin
                            vm[k] = 0;
                        end
                    end
                    if ((newreq & pm[k] & ~taken) != 0) lm[k] = 1;
                    pm[k] = (pm[k] & ~taken) | newreq;
                end
            end
        end
    end

    // Monitor: compare state each cycle, pop expected index on each handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("valid[%0d]", k),   32'(dvld[k]),  32'(vm[k]));
                    chk($sformatf("pending[%0d]", k), 32'(dpend[k]), 32'(pm[k]));
                    chk($sformatf("lost[%0d]", k),    32'(dlost[k]), 32'(lm[k]));
                    if (dvld[k] === 1'b1) begin
                        chk($sformatf("idx_range[%0d]", k), 32'(didx[k] < NN[k]), 32'd1);
                        if (rdy) begin
                            if (exp_q[k].size() == 0) begin
                                chk($sformatf("issue_unexpected[%0d]", k), didx[k], 32'hFFFF_FFFF);
                            end else begin
                                chk($sformatf("issue_idx[%0d]", k), didx[k], 32'(exp_q[k].pop_front()));
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic step(input logic [15:0] r, input logic e, input logic rd, input logic c);
        req = r; en = e; rdy = rd; clr = c;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input logic rd);
        for (int i = 0; i < n; i++) step(16'h0, 1'b1, rd, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; rdy = 1'b1; clr = 1'b0; req = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid[%0d]", k), 32'(dvld[k]), 32'd0);
            chk($sformatf("rst_idx[%0d]", k),   didx[k],       32'd0);
            chk($sformatf("rst_pend[%0d]", k),  32'(dpend[k]), 32'd0);
        end
        rst = 1'b0;

        // Single request, two-edge latency.
        step(16'h0001, 1, 1, 0); idle(4, 1);
        // Multi-hot burst drained back to back.
        step(16'h8421, 1, 1, 0); idle(6, 1);
        // Backpressure holds the slot stable.
        step(16'h0030, 1, 0, 0); idle(6, 0); idle(4, 1);
        // Collision on an already-pending bit, then flush.
        step(16'h0080, 1, 0, 0); idle(2, 0);
        step(16'h0004, 1, 0, 0); step(16'h0004, 1, 0, 0); idle(2, 0);
        idle(3, 1); step(16'h0, 1, 1, 1); idle(2, 1);
        // Two-source round-robin pattern (wrap at 9 for the N=10 instance).
        for (int i = 0; i < 8; i++) step(16'h8201 | 16'h8001, 1, 1, 0);
        step(16'h0, 1, 1, 1); idle(2, 1);

        // Asynchronous reset between edges with work in flight.
        step(16'h01F0, 1, 0, 0); idle(1, 0);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("arst_valid[%0d]", k), 32'(dvld[k]),  32'd0);
            chk($sformatf("arst_pend[%0d]", k),  32'(dpend[k]), 32'd0);
            chk($sformatf("arst_lost[%0d]", k),  32'(dlost[k]), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        // Disabled capture: nothing issued.
        for (int i = 0; i < 5; i++) step(16'hFFFF, 0, 1, 0);
        for (int k = 0; k < 3; k++) chk($sformatf("en0_valid[%0d]", k), 32'(dvld[k]), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] r;
            r = 16'($urandom);
            if ($urandom_range(0, 2) != 0) r = r & 16'($urandom) & 16'($urandom);
            step(r, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
        end
        idle(20, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
